// File: rtl/pwl_logit_5_seq.sv
// Inverse of the 5-slice PWL sigmoid: Q8.8 y -> Q8.8 x using a bit-serial
// restoring divider behind a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for valid_in; in_ready high
// DIV   | 16 restoring-divide iterations, one quotient bit per cycle
// DONE  | x_out valid, held until out_ready
module pwl_logit_5_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic signed [15:0] y_in,
  output logic               valid_out,
  input  logic               out_ready,
  output logic signed [15:0] x_out
);

  localparam logic signed [16:0] Y0    = 17'sd18;
  localparam logic signed [16:0] Y1    = 17'sd69;
  localparam logic signed [16:0] Y2    = 17'sd187;
  localparam logic signed [16:0] Y3    = 17'sd237;
  localparam logic signed [16:0] ICPT0 = 17'sd101;
  localparam logic signed [16:0] ICPT1 = 17'sd128;
  localparam logic signed [16:0] ICPT2 = 17'sd155;
  localparam logic [5:0]         SLP0  = 6'd33;
  localparam logic [5:0]         SLP1  = 6'd59;
  localparam logic [5:0]         SLP2  = 6'd33;
  localparam logic signed [15:0] X_MIN = -16'sd640;
  localparam logic signed [15:0] X_MAX = 16'sd640;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q;
  logic [15:0]        num_q;
  logic [6:0]         rem_q;
  logic [5:0]         dvs_q;
  logic               neg_q;

  logic signed [16:0] y_ext;
  logic               sat_lo, sat_hi;
  logic signed [16:0] icpt_sel;
  logic [5:0]         dvs_sel;
  logic signed [16:0] d;
  logic [7:0]         d_mag;
  logic [7:0]         trial;
  logic               q_bit;
  logic [6:0]         rem_nx;
  logic [15:0]        q_nx;

  always_comb begin
    y_ext  = {y_in[15], y_in};
    sat_lo = (y_ext < Y0);
    sat_hi = (y_ext >= Y3);
    if (y_ext < Y1) begin
      icpt_sel = ICPT0;
      dvs_sel  = SLP0;
    end else if (y_ext < Y2) begin
      icpt_sel = ICPT1;
      dvs_sel  = SLP1;
    end else begin
      icpt_sel = ICPT2;
      dvs_sel  = SLP2;
    end
    d     = y_ext - icpt_sel;
    // In the divided regions |d| <= 83, so 8 bits hold the magnitude
    d_mag = d[16] ? 8'(-d) : d[7:0];
  end

  // Dividend bits enter from num_q[15]; quotient bits refill num_q from the LSB
  always_comb begin
    trial  = {rem_q, num_q[15]};
    q_bit  = (trial >= {2'b00, dvs_q});
    rem_nx = q_bit ? 7'(trial - {2'b00, dvs_q}) : trial[6:0];
    q_nx   = {num_q[14:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (valid_in) state_d = (sat_lo || sat_hi) ? DONE : DIV;
      end
      DIV:     if (cnt_q == 4'd15) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      x_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            if (sat_lo || sat_hi) begin
              x_out     <= sat_hi ? X_MAX : X_MIN;
              valid_out <= 1'b1;
            end else begin
              num_q <= {d_mag, 8'h00};
              rem_q <= '0;
              cnt_q <= '0;
              dvs_q <= dvs_sel;
              neg_q <= d[16];
            end
          end
        end
        DIV: begin
          num_q <= q_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            x_out     <= neg_q ? (16'd0 - q_nx) : q_nx;
            valid_out <= 1'b1;
          end
        end
        DONE:    if (out_ready) valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_logit_5_seq.sv
// Randomized and directed bench for pwl_logit_5_seq against an arithmetic
// model of the inverse sigmoid, with a per-cycle output monitor.
module tb_pwl_logit_5_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic               in_ready;
  logic signed [15:0] y_in;
  logic               valid_out;
  logic               out_ready;
  logic signed [15:0] x_out;

  pwl_logit_5_seq dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .x_out     (x_out)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int lat; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int age = 0;
  bit active = 0;
  bit seen = 0;
  int last_x = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference inverse: pick the segment, invert y = c + x*s/256 exactly,
  // truncating toward zero (SV integer division does exactly that).
  function automatic int golden(input int y);
    if (y < 18)   return -640;
    if (y >= 237) return 640;
    if (y < 69)   return ((y - 101) * 256) / 33;
    if (y < 187)  return ((y - 128) * 256) / 59;
    return ((y - 155) * 256) / 33;
  endfunction

  function automatic int latency(input int y);
    return (y < 18 || y >= 237) ? 1 : 17;
  endfunction

  function automatic int fwd_sigmoid(input int y_region, input int x);
    if (y_region < 69)  return 101 + (x * 33) / 256;
    if (y_region < 187) return 128 + (x * 59) / 256;
    return 155 + (x * 33) / 256;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid_out", valid_out, 0);
      chk("rst_x_out", x_out, 0);
      exp_q.delete();
      active = 0;
      seen   = 0;
    end else begin
      chk("in_ready", in_ready, (exp_q.size() == 0) ? 1 : 0);
      if (exp_q.size() != 0 && !active) begin
        active = 1;
        age    = 0;
      end
      if (active) age++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid_out", valid_out, 0);
        end else begin
          if (!seen) begin
            chk("latency", age, exp_q[0].lat);
            seen = 1;
          end
          chk("x_out", x_out, exp_q[0].x);
          if (out_ready) begin
            last_x = x_out;
            void'(exp_q.pop_front());
            active = 0;
            seen   = 0;
          end
        end
      end else if (active && age >= exp_q[0].lat) begin
        chk("valid_out_late", age, exp_q[0].lat - 1);
        void'(exp_q.pop_front());
        active = 0;
        seen   = 0;
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    valid_in  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic accept(input int y, output bit ok);
    ok = 1;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) begin
      chk("in_ready_wait", in_ready, 1);
      do_reset();
      ok = 0;
      return;
    end
    valid_in = 1'b1;
    y_in     = 16'(y);
    @(posedge clk);
    exp_q.push_back('{x: golden(y), lat: latency(y)});
    #1 valid_in = 1'b0;
  endtask

  task automatic send(input int y, input int stall);
    bit ok;
    int st;
    st = stall;
    accept(y, ok);
    if (!ok) return;
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) return;
      if (valid_out && st > 0) begin
        out_ready = 1'b0;
        st--;
        valid_in  = 1'b1;
        y_in      = 16'($urandom);
      end else if (valid_out) begin
        out_ready = 1'b1;
        valid_in  = 1'b0;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        valid_in  = 1'($urandom_range(0, 1));
        y_in      = 16'($urandom);
      end
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      chk("transfer_timeout", exp_q.size(), 0);
      do_reset();
    end
    valid_in = 1'b0;
  endtask

  task automatic reset_mid(input int y, input int after);
    bit ok;
    out_ready = 1'b0;
    accept(y, ok);
    if (!ok) return;
    repeat (after) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dir_y[10] = '{150, 69, 128, 100, 187, -5, 0, 17, 237, 250};
    int yr;
    rst       = 1'b1;
    valid_in  = 1'b0;
    y_in      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    chk("model_150", golden(150), 95);
    chk("model_69", golden(69), -256);
    chk("model_128", golden(128), 0);
    chk("model_100", golden(100), -121);
    chk("model_187", golden(187), 248);
    chk("model_200", golden(200), 349);
    chk("model_17", golden(17), -640);
    chk("model_237", golden(237), 640);

    foreach (dir_y[i]) send(dir_y[i], 0);

    send(200, 10);

    reset_mid(150, 8);
    reset_mid(250, 3);
    reset_mid(60, 16);

    for (int y = -256; y <= 511; y++) begin
      send(y, 0);
      if (y >= 18 && y < 237) begin
        yr = fwd_sigmoid(y, last_x);
        chk("roundtrip", (yr - y <= 1 && y - yr <= 1) ? 1 : 0, 1);
      end
    end

    for (int n = 0; n < 150; n++) begin
      int y;
      y = (n % 2 == 0) ? $urandom_range(0, 300) - 20 : int'($signed(16'($urandom)));
      send(y, $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
